// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry adds two WIDTH-bit
// operands LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic fa_s, fa_co, last_bit;
    logic [WIDTH-1:0] psum_shift;

    // Full-adder cell on the current LSBs and the carry flop.
    assign fa_s     = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign fa_co    = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    assign last_bit = (cnt_q == LastBit);

    // Works for WIDTH = 1, where the shifted-in bit is the whole result.
    always_comb begin
        psum_shift            = psum_q >> 1;
        psum_shift[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    psum_d  = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                psum_d  = psum_shift;
                carry_d = fa_co;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    sum_d  = psum_shift;
                    cout_d = fa_co;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH = 8 and WIDTH = 1.
module tb_serial_adder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] exp8_q[$];
    int         t08_q[$];
    logic [1:0] exp1_q[$];
    int         t01_q[$];

    logic [8:0] m8_e;
    int         m8_t;
    logic [1:0] m1_e;
    int         m1_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output side of the scoreboards: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (reset_n) begin
            check("excl8", 32'(busy8 & done8), 0);
            check("excl1", 32'(busy1 & done1), 0);
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    check("spurious_done8", 32'(done8), 0);
                end else begin
                    m8_e = exp8_q.pop_front();
                    m8_t = t08_q.pop_front();
                    check("sum8", 32'(sum8), 32'(m8_e[7:0]));
                    check("cout8", 32'(cout8), 32'(m8_e[8]));
                    check("lat8", cyc - m8_t, 8);
                end
            end
            if (done1) begin
                if (exp1_q.size() == 0) begin
                    check("spurious_done1", 32'(done1), 0);
                end else begin
                    m1_e = exp1_q.pop_front();
                    m1_t = t01_q.pop_front();
                    check("sum1", 32'(sum1), 32'(m1_e[0]));
                    check("cout1", 32'(cout1), 32'(m1_e[1]));
                    check("lat1", cyc - m1_t, 1);
                end
            end
        end
    end

    task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input bit disturb);
        int nbusy = 0;
        bit seen = 0;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        exp8_q.push_back(9'(a) + 9'(b) + 9'(c));
        t08_q.push_back(cyc);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy8) nbusy++;
            if (done8) begin
                seen = 1;
            end else if (disturb) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                cin8 = 1'($urandom);
                start8 = 1'(i);
            end
        end
        start8 = 1'b0;
        check("done_seen8", 32'(seen), 1);
        check("busy_len8", nbusy, 8);
    endtask

    task automatic do_add1(input logic a, input logic b, input logic c);
        int nbusy = 0;
        bit seen = 0;
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        exp1_q.push_back(2'(a) + 2'(b) + 2'(c));
        t01_q.push_back(cyc);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (busy1) nbusy++;
            if (done1) seen = 1;
        end
        check("done_seen1", 32'(seen), 1);
        check("busy_len1", nbusy, 1);
    endtask

    // start held high: accepts at t0, t0+10, t0+20; drop start after the third done.
    task automatic b2b8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int t0;
        int nd = 0;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp8_q.push_back(9'(a) + 9'(b) + 9'(c));
            t08_q.push_back(t0 + 10 * k);
        end
        for (int i = 0; i < 60 && nd < 3; i++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        start8 = 1'b0;
        check("b2b_dones", nd, 3);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_sum8", 32'(sum8), 0);
            check("rst_cout8", 32'(cout8), 0);
            check("rst_busy8", 32'(busy8), 0);
            check("rst_done8", 32'(done8), 0);
            check("rst_busy1", 32'(busy1), 0);
        end

        do_add8(8'h00, 8'h00, 1'b0, 0);
        do_add8(8'h7F, 8'h01, 1'b0, 0);
        do_add8(8'h3C, 8'h15, 1'b1, 0);
        do_add8(8'hFF, 8'h01, 1'b0, 0);
        do_add8(8'hA5, 8'h5A, 1'b1, 0);
        do_add8(8'h3C, 8'h15, 1'b1, 1);
        do_add8(8'h9D, 8'hC7, 1'b1, 0);
        b2b8(8'h81, 8'h42, 1'b1);

        // Abort 0xFF + 0x01 after four bits; outputs must clear without a clock.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort_busy_pre", 32'(busy8), 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 0);
        check("abort_sum", 32'(sum8), 0);
        check("abort_cout", 32'(cout8), 0);
        check("abort_done", 32'(done8), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_idle", 32'(busy8), 0);
        do_add8(8'h12, 8'h34, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            do_add1(i[2], i[1], i[0]);
        end

        repeat (5) @(negedge clk);
        check("sb8_empty", exp8_q.size(), 0);
        check("sb1_empty", exp1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands one bit per clock through a single full-adder cell and a registered carry. It sits directly upstream of the full-adder cell: it sequences the a/b/cin inputs into the cell, takes back s/cout, and assembles the multi-bit result. A start/busy/done handshake is provided for the lab top level or a host FSM.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 1 to 32.
- clk  input  1  rising-edge system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when sum/cout become valid (DONE state).
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

## Operation

- Reset is asynchronous and active-low. It has these effects:
  - state = IDLE.
  - Operand shift registers, partial-sum register, carry flop and bit counter are cleared.
  - sum = 0, cout = 0, busy = 0, done = 0.
- The FSM has three states: IDLE, SHIFT and DONE.
- In IDLE with start = 1 at a rising edge:
  - Load a into opa and b into opb.
  - Load cin into the carry flop and clear the bit counter.
  - Go to SHIFT.
- In IDLE with start = 0, stay in IDLE.
- Each SHIFT cycle evaluates the full-adder cell combinationally on opa[0], opb[0] and the carry flop:
  - s = opa[0] ^ opb[0] ^ c.
  - co = majority(opa[0], opb[0], c).
- On each SHIFT edge:
  - opa and opb shift right by one, with zero fill.
  - The partial sum shifts right with s inserted at the MSB.
  - The carry flop takes co.
  - The counter increments.
- When the counter reaches WIDTH-1, the SHIFT edge also does the following:
  - Captures {s, partial_sum[WIDTH-1:1]} into sum.
  - Captures co into cout.
  - Goes to DONE.
- From DONE, go to IDLE unconditionally on the next edge.
- sum and cout hold their last values until the next completion or reset. They never show intermediate partial sums.
- start is ignored in SHIFT and DONE. A start held high through DONE is accepted on the first IDLE edge.
- Operands are captured once. Changes on a, b or cin after the accepting edge have no effect on the current operation.
- Width rules: the counter is $clog2(WIDTH) bits, with a minimum of 1. The result equals (a + b + cin) mod 2^WIDTH, and cout is the overflow bit.
- WIDTH = 1 degenerates to a single SHIFT cycle. The output must match the full-adder truth table exactly.

## Timing

- Edge E0 accepts start; the machine is in SHIFT from E0.
- SHIFT edges E1 through E_WIDTH each process one bit.
- busy is high in the cycles between E0 and E_WIDTH, which is exactly WIDTH cycles.
- Edge E_WIDTH updates sum and cout. done is high for the single cycle after E_WIDTH.
- Edge E_WIDTH+1 returns the machine to IDLE.
- Latency from the accepting edge to done rising is WIDTH cycles. Throughput is one addition per WIDTH+2 cycles.
- busy and done are decoded from registered state and are never high together.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock. No done is produced for the aborted operation.
- After reset deasserts, the first edge with start = 1 starts a fresh addition.

## Test plan

- Reset then idle: hold reset_n = 0 for 3 cycles, then release. Required: sum = 0x00, cout = 0, busy = 0, done = 0, and start = 0 keeps the block in IDLE.
- WIDTH = 8 basic adds, each checked when done is high:
  - a = 0x00, b = 0x00, cin = 0 gives sum = 0x00, cout = 0.
  - a = 0x7F, b = 0x01, cin = 0 gives sum = 0x80, cout = 0.
  - a = 0x3C, b = 0x15, cin = 1 gives sum = 0x52, cout = 0.
- Full carry ripple:
  - a = 0xFF, b = 0x01, cin = 0 gives sum = 0x00, cout = 1.
  - a = 0xA5, b = 0x5A, cin = 1 gives sum = 0x00, cout = 1.
  - In both cases done rises exactly 8 cycles after the accepting edge.
- Handshake and operand isolation:
  - Change a/b and pulse start during SHIFT; the in-flight result is unchanged and busy stays high for exactly 8 cycles.
  - Holding start high continuously yields back-to-back operations, with done every 10 cycles.
- Reset mid-operation: assert reset_n = 0 after 4 SHIFT cycles of 0xFF + 0x01. Required: busy = 0, sum = 0x00, cout = 0 immediately, and no done pulse. A following 0x12 + 0x34, cin = 0 gives sum = 0x46, cout = 0.
- WIDTH = 1 exhaustive: run all 8 {a, b, cin} combinations. Required: sum = a ^ b ^ cin, cout = majority, and done 1 cycle after each accept.
